// File: rtl/arb_requester.sv
// Client-side initiator for the 2-bit request/grant arbiter: accepts a burst command,
// requests the bus, counts granted beats, then releases it for one cycle.
module arb_requester #(
    parameter int ID      = 0,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_ready,
    input  logic [1:0]       grant,
    output logic             req,
    output logic             beat_valid,
    output logic [LEN_W-1:0] beat_idx,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    localparam logic [1:0]      GMASK   = 2'(1 << ID);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        OWN     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_idx_q, beat_idx_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             req_q, req_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             timeout_err_q, timeout_err_d;

    logic granted;
    logic in_burst;

    // Only the exact one-hot pattern for this port is a grant; 2'b11 is an arbiter fault.
    assign granted    = (grant == GMASK);
    assign in_burst   = (state_q == REQ) || (state_q == OWN);
    assign beat_valid = in_burst && granted;

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        beat_idx_d    = beat_idx_q;
        to_cnt_d      = to_cnt_q;
        timeout_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    len_d      = cmd_len;
                    beat_idx_d = '0;
                    to_cnt_d   = '0;
                    state_d    = REQ;
                end
            end
            REQ, OWN: begin
                if (beat_valid) begin
                    if (beat_idx_q == len_q) begin
                        state_d = RELEASE;
                    end else begin
                        beat_idx_d = beat_idx_q + LEN_W'(1);
                        state_d    = OWN;
                    end
                end else if (state_q == REQ) begin
                    // Once a beat has been granted, preemption is a stall, never a timeout.
                    if (to_cnt_q == TO_LAST) begin
                        state_d       = IDLE;
                        timeout_err_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_d       = (state_d == REQ) || (state_d == OWN);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == RELEASE);
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            len_q         <= '0;
            beat_idx_q    <= '0;
            to_cnt_q      <= '0;
            req_q         <= 1'b0;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            beat_idx_q    <= beat_idx_d;
            to_cnt_q      <= to_cnt_d;
            req_q         <= req_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign req         = req_q;
    assign beat_idx    = beat_idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;

    a_done_err_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(done_q && timeout_err_q));

    a_beat_in_range: assert property (@(posedge clk) disable iff (reset)
        beat_valid |-> (beat_idx_q <= len_q));

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: two instances (ID 0 and ID 1) share a bench-driven grant bus.
module tb_arb_requester;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] grant = 2'b00;

    logic       cv0 = 1'b0, cv1 = 1'b0;
    logic [3:0] len0 = 4'd0, len1 = 4'd0;
    logic       rdy0, req0, bv0, busy0, done0, terr0;
    logic       rdy1, req1, bv1, busy1, done1, terr1;
    logic [3:0] idx0, idx1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    arb_requester #(.ID(0), .LEN_W(4), .TIMEOUT(16), .TO_W(5)) dut0 (
        .clk(clk), .reset(reset), .cmd_valid(cv0), .cmd_len(len0), .cmd_ready(rdy0),
        .grant(grant), .req(req0), .beat_valid(bv0), .beat_idx(idx0), .busy(busy0),
        .done(done0), .timeout_err(terr0)
    );

    arb_requester #(.ID(1), .LEN_W(4), .TIMEOUT(4), .TO_W(5)) dut1 (
        .clk(clk), .reset(reset), .cmd_valid(cv1), .cmd_len(len1), .cmd_ready(rdy1),
        .grant(grant), .req(req1), .beat_valid(bv1), .beat_idx(idx1), .busy(busy1),
        .done(done1), .timeout_err(terr1)
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) next_cycle;
        reset = 1'b0;
        #1;
        n_tests++; if (rdy0 !== 1'b1)  begin n_fail++; $display("[TB] FAIL reset.rdy0 got %b expected 1", rdy0); end
        n_tests++; if (req0 !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset.req0 got %b expected 0", req0); end
        n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset.busy0 got %b expected 0", busy0); end
        n_tests++; if (done0 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset.done0 got %b expected 0", done0); end
        n_tests++; if (terr0 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset.terr0 got %b expected 0", terr0); end
        n_tests++; if (idx0 !== 4'd0)  begin n_fail++; $display("[TB] FAIL reset.idx0 got %0d expected 0", idx0); end
        n_tests++; if (bv0 !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset.bv0 got %b expected 0", bv0); end
        n_tests++; if (rdy1 !== 1'b1)  begin n_fail++; $display("[TB] FAIL reset.rdy1 got %b expected 1", rdy1); end
        n_tests++; if (req1 !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset.req1 got %b expected 0", req1); end
        n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset.busy1 got %b expected 0", busy1); end
        n_tests++; if (terr1 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset.terr1 got %b expected 0", terr1); end
        next_cycle;
    endtask

    // ID 0 alone, three beats; cycles are counted from the accept edge.
    task automatic test_basic;
        logic [1:0] g      [6] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        logic       e_req  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       e_bv   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] e_idx  [6] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0};
        logic       e_done [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       e_busy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       e_rdy  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        cv0 = 1'b1; len0 = 4'd2;
        for (int c = 0; c < 6; c++) begin
            next_cycle;
            cv0 = 1'b0;
            grant = g[c];
            #1;
            n_tests++; if (req0 !== e_req[c])   begin n_fail++; $display("[TB] FAIL basic.req cycle %0d got %b expected %b", c + 1, req0, e_req[c]); end
            n_tests++; if (bv0 !== e_bv[c])     begin n_fail++; $display("[TB] FAIL basic.beat_valid cycle %0d got %b expected %b", c + 1, bv0, e_bv[c]); end
            n_tests++; if (done0 !== e_done[c]) begin n_fail++; $display("[TB] FAIL basic.done cycle %0d got %b expected %b", c + 1, done0, e_done[c]); end
            n_tests++; if (busy0 !== e_busy[c]) begin n_fail++; $display("[TB] FAIL basic.busy cycle %0d got %b expected %b", c + 1, busy0, e_busy[c]); end
            n_tests++; if (rdy0 !== e_rdy[c])   begin n_fail++; $display("[TB] FAIL basic.cmd_ready cycle %0d got %b expected %b", c + 1, rdy0, e_rdy[c]); end
            if (e_bv[c]) begin
                n_tests++; if (idx0 !== e_idx[c]) begin n_fail++; $display("[TB] FAIL basic.beat_idx cycle %0d got %0d expected %0d", c + 1, idx0, e_idx[c]); end
            end
        end
        grant = 2'b00;
        next_cycle;
    endtask

    // ID 1 runs a 4-beat burst; ID 0 takes the bus for one beat after ID 1's first beat.
    task automatic test_preempt;
        logic [1:0] g       [12] = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        logic       e_req1  [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       e_bv1   [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] e_idx1  [12] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0};
        logic       e_done1 [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       e_bv0   [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       e_done0 [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        cv1 = 1'b1; len1 = 4'd3;
        for (int c = 0; c < 12; c++) begin
            next_cycle;
            cv1 = 1'b0;
            cv0 = (c == 0);
            len0 = 4'd0;
            grant = g[c];
            #1;
            n_tests++; if (req1 !== e_req1[c])   begin n_fail++; $display("[TB] FAIL preempt.req1 cycle %0d got %b expected %b", c + 1, req1, e_req1[c]); end
            n_tests++; if (bv1 !== e_bv1[c])     begin n_fail++; $display("[TB] FAIL preempt.beat_valid1 cycle %0d got %b expected %b", c + 1, bv1, e_bv1[c]); end
            n_tests++; if (done1 !== e_done1[c]) begin n_fail++; $display("[TB] FAIL preempt.done1 cycle %0d got %b expected %b", c + 1, done1, e_done1[c]); end
            n_tests++; if (terr1 !== 1'b0)       begin n_fail++; $display("[TB] FAIL preempt.timeout_err1 cycle %0d got %b expected 0", c + 1, terr1); end
            n_tests++; if (bv0 !== e_bv0[c])     begin n_fail++; $display("[TB] FAIL preempt.beat_valid0 cycle %0d got %b expected %b", c + 1, bv0, e_bv0[c]); end
            n_tests++; if (done0 !== e_done0[c]) begin n_fail++; $display("[TB] FAIL preempt.done0 cycle %0d got %b expected %b", c + 1, done0, e_done0[c]); end
            if (c < 10) begin
                n_tests++; if (idx1 !== e_idx1[c]) begin n_fail++; $display("[TB] FAIL preempt.beat_idx1 cycle %0d got %0d expected %0d", c + 1, idx1, e_idx1[c]); end
            end
        end
        cv0 = 1'b0;
        grant = 2'b00;
        next_cycle;
    endtask

    // ID 1 with TIMEOUT=4 while the grant is stuck on the other port.
    task automatic test_timeout;
        logic e_req1  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic e_terr1 [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic e_busy1 [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        cv1 = 1'b1; len1 = 4'd2;
        for (int c = 0; c < 6; c++) begin
            next_cycle;
            cv1 = 1'b0;
            grant = 2'b01;
            #1;
            n_tests++; if (req1 !== e_req1[c])   begin n_fail++; $display("[TB] FAIL timeout.req1 cycle %0d got %b expected %b", c + 1, req1, e_req1[c]); end
            n_tests++; if (terr1 !== e_terr1[c]) begin n_fail++; $display("[TB] FAIL timeout.timeout_err1 cycle %0d got %b expected %b", c + 1, terr1, e_terr1[c]); end
            n_tests++; if (busy1 !== e_busy1[c]) begin n_fail++; $display("[TB] FAIL timeout.busy1 cycle %0d got %b expected %b", c + 1, busy1, e_busy1[c]); end
            n_tests++; if (done1 !== 1'b0)       begin n_fail++; $display("[TB] FAIL timeout.done1 cycle %0d got %b expected 0", c + 1, done1); end
            n_tests++; if (bv1 !== 1'b0)         begin n_fail++; $display("[TB] FAIL timeout.beat_valid1 cycle %0d got %b expected 0", c + 1, bv1); end
            n_tests++; if (bv0 !== 1'b0)         begin n_fail++; $display("[TB] FAIL timeout.idle_grant_ignored cycle %0d got %b expected 0", c + 1, bv0); end
        end
        n_tests++; if (rdy1 !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout.cmd_ready1 got %b expected 1", rdy1); end
        grant = 2'b00;
        next_cycle;
    endtask

    // First grant arrives on exactly the cycle the timeout counter expires.
    task automatic test_timeout_edge;
        logic [1:0] g       [6] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00};
        logic       e_req1  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       e_bv1   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] e_idx1  [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
        logic       e_done1 [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        cv1 = 1'b1; len1 = 4'd1;
        for (int c = 0; c < 6; c++) begin
            next_cycle;
            cv1 = 1'b0;
            grant = g[c];
            #1;
            n_tests++; if (req1 !== e_req1[c])   begin n_fail++; $display("[TB] FAIL tedge.req1 cycle %0d got %b expected %b", c + 1, req1, e_req1[c]); end
            n_tests++; if (bv1 !== e_bv1[c])     begin n_fail++; $display("[TB] FAIL tedge.beat_valid1 cycle %0d got %b expected %b", c + 1, bv1, e_bv1[c]); end
            n_tests++; if (done1 !== e_done1[c]) begin n_fail++; $display("[TB] FAIL tedge.done1 cycle %0d got %b expected %b", c + 1, done1, e_done1[c]); end
            n_tests++; if (terr1 !== 1'b0)       begin n_fail++; $display("[TB] FAIL tedge.timeout_err1 cycle %0d got %b expected 0", c + 1, terr1); end
            if (e_bv1[c]) begin
                n_tests++; if (idx1 !== e_idx1[c]) begin n_fail++; $display("[TB] FAIL tedge.beat_idx1 cycle %0d got %0d expected %0d", c + 1, idx1, e_idx1[c]); end
            end
        end
        next_cycle;
        n_tests++; if (rdy1 !== 1'b1) begin n_fail++; $display("[TB] FAIL tedge.cmd_ready1 got %b expected 1", rdy1); end
    endtask

    // Reset lands while ID 0 shows beat 2, then a fresh 2-beat burst must run cleanly.
    task automatic test_reset_mid;
        logic [1:0] g2     [4] = '{2'b00, 2'b01, 2'b01, 2'b00};
        logic       e_req  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic       e_bv   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] e_idx  [4] = '{4'd0, 4'd0, 4'd1, 4'd0};
        logic       e_done [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        cv0 = 1'b1; len0 = 4'd4;
        for (int c = 0; c < 4; c++) begin
            next_cycle;
            cv0 = 1'b0;
            grant = (c == 0) ? 2'b00 : 2'b01;
        end
        #1;
        n_tests++; if (bv0 !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid.pre_beat_valid got %b expected 1", bv0); end
        n_tests++; if (idx0 !== 4'd2) begin n_fail++; $display("[TB] FAIL rmid.pre_beat_idx got %0d expected 2", idx0); end
        reset = 1'b1;
        next_cycle;
        reset = 1'b0;
        #1;
        n_tests++; if (req0 !== 1'b0)  begin n_fail++; $display("[TB] FAIL rmid.req got %b expected 0", req0); end
        n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid.busy got %b expected 0", busy0); end
        n_tests++; if (idx0 !== 4'd0)  begin n_fail++; $display("[TB] FAIL rmid.beat_idx got %0d expected 0", idx0); end
        n_tests++; if (done0 !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid.done got %b expected 0", done0); end
        n_tests++; if (terr0 !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid.timeout_err got %b expected 0", terr0); end
        n_tests++; if (bv0 !== 1'b0)   begin n_fail++; $display("[TB] FAIL rmid.beat_valid got %b expected 0", bv0); end
        n_tests++; if (rdy0 !== 1'b1)  begin n_fail++; $display("[TB] FAIL rmid.cmd_ready got %b expected 1", rdy0); end
        cv0 = 1'b1; len0 = 4'd1;
        for (int c = 0; c < 4; c++) begin
            next_cycle;
            cv0 = 1'b0;
            grant = g2[c];
            #1;
            n_tests++; if (req0 !== e_req[c])   begin n_fail++; $display("[TB] FAIL rmid.fresh_req cycle %0d got %b expected %b", c + 1, req0, e_req[c]); end
            n_tests++; if (bv0 !== e_bv[c])     begin n_fail++; $display("[TB] FAIL rmid.fresh_beat_valid cycle %0d got %b expected %b", c + 1, bv0, e_bv[c]); end
            n_tests++; if (done0 !== e_done[c]) begin n_fail++; $display("[TB] FAIL rmid.fresh_done cycle %0d got %b expected %b", c + 1, done0, e_done[c]); end
            if (e_bv[c]) begin
                n_tests++; if (idx0 !== e_idx[c]) begin n_fail++; $display("[TB] FAIL rmid.fresh_beat_idx cycle %0d got %0d expected %0d", c + 1, idx0, e_idx[c]); end
            end
        end
        grant = 2'b00;
        next_cycle;
    endtask

    // Burst of len+1 beats on ID 0 with a one-cycle 2'b11 glitch before the first real grant.
    task automatic test_len_bounds(input logic [3:0] len);
        int beats    = 0;
        int done_cnt = 0;
        int done_at  = 0;
        cv0 = 1'b1; len0 = len;
        for (int c = 1; c <= 24; c++) begin
            next_cycle;
            cv0 = 1'b0;
            grant = (c == 1) ? 2'b00 : ((c == 2) ? 2'b11 : 2'b01);
            #1;
            if (c == 2) begin
                n_tests++; if (bv0 !== 1'b0) begin n_fail++; $display("[TB] FAIL len%0d.grant11_beat got %b expected 0", len, bv0); end
            end
            if (bv0 === 1'b1) begin
                n_tests++; if (idx0 !== 4'(beats)) begin n_fail++; $display("[TB] FAIL len%0d.beat_idx cycle %0d got %0d expected %0d", len, c, idx0, beats); end
                beats++;
            end
            if (done0 === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
        end
        n_tests++; if (beats != int'(len) + 1) begin n_fail++; $display("[TB] FAIL len%0d.beat_count got %0d expected %0d", len, beats, int'(len) + 1); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("[TB] FAIL len%0d.done_count got %0d expected 1", len, done_cnt); end
        n_tests++; if (done_at != int'(len) + 4) begin n_fail++; $display("[TB] FAIL len%0d.done_cycle got %0d expected %0d", len, done_at, int'(len) + 4); end
        grant = 2'b00;
        next_cycle;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_preempt;
        test_timeout;
        test_timeout_edge;
        test_reset_mid;
        test_len_bounds(4'd0);
        test_len_bounds(4'd15);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired after %0t, run did not complete", $time);
        $fatal(1, "[TB] watchdog");
    end

endmodule
